pcie_rq_arbiter: RTL

//  Shares one PCIe sub-controller request port between NUM_REQ requesters (e.g. DMA channels).
//  The read channel (RdRq*) and write channel (WrRq*) are arbitrated independently, each round-robin.

---
 rtl/pcie_rq_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pcie_rq_arbiter.sv
// pcie_rq_arbiter
//   Shares one PCIe sub-controller request port between NUM_REQ requesters.
//   Read and write channels are arbitrated independently, each round-robin,
//   each with one outstanding transaction and a watchdog that aborts
//   transactions the controller never completes.
//
// Ports (clk / rst_n async active-low):
//   ReqRd*  : requester-side read  (Valid/Addr in, Ready/Err/Data out)
//   ReqWr*  : requester-side write (Valid/Addr/Data in, Ready/Err out)
//   RdRq*   : controller-side read  (Valid/Addr out, Data/Ready/Err in)
//   WrRq*   : controller-side write (Valid/Addr/Data out, Ready/Err in)
//   RdGnt/WrGnt         : one-hot grant owner, 0 when idle
//   RdTimeout/WrTimeout : one-cycle pulse on watchdog abort
//
// pcie_rq_chan holds one channel (arbiter, FSM, watchdog, response routing);
// the request payload width PW is the only difference between read and write.

module pcie_rq_chan #(
  parameter int N       = 2,
  parameter int PW      = 64,
  parameter int TIMEOUT = 256,
  parameter int TMR_W   = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        i_valid,
  input  logic [N-1:0][PW-1:0] i_payload,
  input  logic                i_rq_ready,
  input  logic                i_rq_err,
  output logic                o_rq_valid,
  output logic [PW-1:0]       o_rq_payload,
  output logic [N-1:0]        o_ready,
  output logic [N-1:0]        o_err,
  output logic [N-1:0]        o_gnt,
  output logic                o_timeout
);

  localparam int IW = $clog2(N);
  localparam logic [TMR_W-1:0] WD_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_ptr;      // last winner; doubles as the owner index
  logic [IW-1:0]    w_pick, w_cand;
  logic             w_any, w_grant, w_cpl, w_abort;
  logic [TMR_W-1:0] r_wd;
  logic             r_rq_valid, r_timeout;
  logic [PW-1:0]    r_rq_payload;
  logic [N-1:0]     r_ready, r_err, r_gnt;
  logic [N-1:0]     w_pick_oh, w_own_oh;

  // Round-robin pick: scan from farthest to nearest so the first requester
  // at or after ptr+1 is the last one written.
  always_comb begin
    w_pick = '0;
    w_cand = '0;
    w_any  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      w_cand = IW'((int'(r_ptr) + k) % N);
      if (i_valid[w_cand]) begin
        w_pick = w_cand;
        w_any  = 1'b1;
      end
    end
  end

  assign w_pick_oh = N'(1) << w_pick;
  assign w_own_oh  = N'(1) << r_ptr;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_cpl       = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) begin
        w_grant     = 1'b1;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // A completion in the final watchdog cycle still wins over the abort.
        if (i_rq_ready) begin
          w_cpl       = 1'b1;
          w_state_nxt = S_RESP;
        end else if (TIMEOUT != 0 && r_wd == WD_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= IW'(N - 1);
      r_wd         <= '0;
      r_rq_valid   <= 1'b0;
      r_rq_payload <= '0;
      r_ready      <= '0;
      r_err        <= '0;
      r_gnt        <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr        <= w_pick;
        r_rq_payload <= i_payload[w_pick];
        r_rq_valid   <= 1'b1;
        r_gnt        <= w_pick_oh;
        r_wd         <= '0;
      end
      if (r_state == S_ISSUE && TIMEOUT != 0)
        r_wd <= r_wd + 1'b1;
      if (w_cpl || w_abort) begin
        r_rq_valid <= 1'b0;
        r_gnt      <= '0;
        r_ready    <= w_own_oh;
        r_err      <= (w_abort || i_rq_err) ? w_own_oh : '0;
        r_timeout  <= w_abort;
      end
      if (r_state == S_RESP) begin
        r_ready   <= '0;
        r_err     <= '0;
        r_timeout <= 1'b0;
      end
    end
  end

  assign o_rq_valid   = r_rq_valid;
  assign o_rq_payload = r_rq_payload;
  assign o_ready      = r_ready;
  assign o_err        = r_err;
  assign o_gnt        = r_gnt;
  assign o_timeout    = r_timeout;

endmodule

module pcie_rq_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256,
  parameter int TMR_W   = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     ReqRdValid,
  input  logic [NUM_REQ*64-1:0]  ReqRdAddr,
  output logic [NUM_REQ-1:0]     ReqRdReady,
  output logic [NUM_REQ-1:0]     ReqRdErr,
  output logic [127:0]           ReqRdData,
  input  logic [NUM_REQ-1:0]     ReqWrValid,
  input  logic [NUM_REQ*64-1:0]  ReqWrAddr,
  input  logic [NUM_REQ*128-1:0] ReqWrData,
  output logic [NUM_REQ-1:0]     ReqWrReady,
  output logic [NUM_REQ-1:0]     ReqWrErr,
  output logic                   RdRqValid,
  output logic [63:0]            RdRqAddr,
  input  logic [127:0]           RdRqData,
  input  logic                   RdRqReady,
  input  logic                   RdRqErr,
  output logic                   WrRqValid,
  output logic [63:0]            WrRqAddr,
  output logic [127:0]           WrRqData,
  input  logic                   WrRqReady,
  input  logic                   WrRqErr,
  output logic [NUM_REQ-1:0]     RdGnt,
  output logic [NUM_REQ-1:0]     WrGnt,
  output logic                   RdTimeout,
  output logic                   WrTimeout
);

  logic [NUM_REQ-1:0][63:0]  w_rd_pl;
  logic [NUM_REQ-1:0][191:0] w_wr_pl;
  logic [191:0]              w_wr_out;
  logic [127:0]              r_rd_data;

  assign w_rd_pl = ReqRdAddr;

  // Write payload per requester: {data, addr}.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wr_pl
    assign w_wr_pl[g] = {ReqWrData[128*g +: 128], ReqWrAddr[64*g +: 64]};
  end

  pcie_rq_chan #(.N(NUM_REQ), .PW(64), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) u_rd (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (ReqRdValid),
    .i_payload    (w_rd_pl),
    .i_rq_ready   (RdRqReady),
    .i_rq_err     (RdRqErr),
    .o_rq_valid   (RdRqValid),
    .o_rq_payload (RdRqAddr),
    .o_ready      (ReqRdReady),
    .o_err        (ReqRdErr),
    .o_gnt        (RdGnt),
    .o_timeout    (RdTimeout)
  );

  pcie_rq_chan #(.N(NUM_REQ), .PW(192), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) u_wr (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (ReqWrValid),
    .i_payload    (w_wr_pl),
    .i_rq_ready   (WrRqReady),
    .i_rq_err     (WrRqErr),
    .o_rq_valid   (WrRqValid),
    .o_rq_payload (w_wr_out),
    .o_ready      (ReqWrReady),
    .o_err        (ReqWrErr),
    .o_gnt        (WrGnt),
    .o_timeout    (WrTimeout)
  );

  assign WrRqAddr = w_wr_out[63:0];
  assign WrRqData = w_wr_out[191:64];

  // Grant is non-zero exactly while the read channel is in ISSUE, so this
  // captures only genuine completions; late or spurious Ready is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_rd_data <= '0;
    else if (RdRqReady && |RdGnt)  r_rd_data <= RdRqData;
  end

  assign ReqRdData = r_rd_data;

endmodule
